// File: rtl/rr_arbiter4_pkg.sv
// Shared types and helpers for the four-way round-robin arbiter.
package arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/rr_arbiter4_pick.sv
// Rotating priority picker: first set request starting at index ptr, wrapping mod 4.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               any,
    output logic [IDX_W-1:0]   idx
);

    logic [NUM_REQ-1:0] rot;
    logic [IDX_W-1:0]   enc;

    always_comb begin
        rot = '0;
        // rot[0] is the requester currently holding top priority
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            rot[i] = req[IDX_W'(i + 32'(ptr))];
        end

        enc = '0;
        if (rot[0])      enc = 2'd0;
        else if (rot[1]) enc = 2'd1;
        else if (rot[2]) enc = 2'd2;
        else if (rot[3]) enc = 2'd3;

        any = |req;
        idx = enc + ptr;
    end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with grant hold, release on done/abandon,
// and an optional hold-limit forced release.
module rr_arbiter4
    import arb_pkg::*;
#(
    parameter int HOLD_MAX = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
    logic               timeout_q, timeout_d;

    logic               pick_any;
    logic [IDX_W-1:0]   pick_idx;
    logic               owner_req;
    logic               hit_limit;
    logic               release_now;

    rr_pick4 u_pick (
        .req (req),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        timeout_d = 1'b0;

        owner_req   = req[gnt_idx_q];
        hit_limit   = (HOLD_MAX != 0) && (cnt_q == CNT_W'(HOLD_MAX));
        release_now = done || !owner_req || hit_limit;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d   = GRANT;
                    gnt_d     = onehot(pick_idx);
                    gnt_idx_d = pick_idx;
                    cnt_d     = CNT_W'(1);
                end
            end
            GRANT: begin
                if (release_now) begin
                    state_d   = IDLE;
                    gnt_d     = '0;
                    gnt_idx_d = '0;
                    cnt_d     = '0;
                    ptr_d     = gnt_idx_q + 2'd1;
                    // A voluntary release on the same edge masks the forced one
                    timeout_d = hit_limit && !done && owner_req;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            gnt_idx_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = |gnt_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Self-checking bench for rr_arbiter4 against a cycle-level behavioural model.
module tb_rr_arbiter4;

    localparam int HOLD_MAX = 8;
    localparam int CNT_W    = 4;
    localparam int CNT_SAT  = (1 << CNT_W) - 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int checks   = 0;
    int failures = 0;

    // behavioural model state
    bit m_busy;
    int m_owner;
    int m_ptr;
    int m_cnt;
    bit m_to;

    rr_arbiter4 #(.HOLD_MAX(HOLD_MAX), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_vec();
        logic [3:0] g;
        g = m_busy ? 4'(1 << m_owner) : 4'b0000;
        return {g, (m_busy ? 2'(m_owner) : 2'd0), m_busy, m_to};
    endfunction

    function automatic logic [7:0] got_vec();
        return {gnt, gnt_idx, gnt_valid, timeout};
    endfunction

    task automatic model_reset();
        m_busy  = 0;
        m_owner = 0;
        m_ptr   = 0;
        m_cnt   = 0;
        m_to    = 0;
    endtask

    // Advance the model by the rules for one rising edge using current inputs.
    task automatic model_edge();
        bit by_done, by_drop, by_limit;
        if (!m_busy) begin
            m_to = 0;
            if (req != 4'b0000) begin
                for (int j = 0; j < 4; j++) begin
                    if (!m_busy && req[(m_ptr + j) % 4]) begin
                        m_busy  = 1;
                        m_owner = (m_ptr + j) % 4;
                        m_cnt   = 1;
                    end
                end
            end
        end else begin
            by_done  = done;
            by_drop  = !req[m_owner];
            by_limit = (HOLD_MAX != 0) && (m_cnt == HOLD_MAX);
            if (by_done || by_drop || by_limit) begin
                m_busy  = 0;
                m_ptr   = (m_owner + 1) % 4;
                m_to    = by_limit && !by_done && !by_drop;
                m_owner = 0;
                m_cnt   = 0;
            end else begin
                m_to  = 0;
                m_cnt = (m_cnt + 1 > CNT_SAT) ? CNT_SAT : m_cnt + 1;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (got_vec() !== 8'b0) begin
            failures++;
            $display("FAIL reset_state got=%b exp=%b", got_vec(), 8'b0);
        end
        tick();
        checks++;
        if (got_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL reset_idle got=%b exp=%b", got_vec(), exp_vec());
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0001;
        tick();
        checks++;
        if (gnt !== 4'b0001 || gnt_idx !== 2'd0 || gnt_valid !== 1'b1) begin
            failures++;
            $display("FAIL single_grant got=%b exp=%b", got_vec(), 8'b0001_00_1_0);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++;
        if (got_vec() !== 8'b0) begin
            failures++;
            $display("FAIL single_release got=%b exp=%b", got_vec(), 8'b0);
        end
        // ptr is now 1: with req 0011 requester 1 must win
        req = 4'b0011;
        tick();
        checks++;
        if (gnt !== 4'b0010 || gnt_idx !== 2'd1) begin
            failures++;
            $display("FAIL single_ptr_adv got=%b exp=%b", got_vec(), 8'b0010_01_1_0);
        end
    endtask

    task automatic test_rotation();
        int order[$];
        int want[5] = '{0, 1, 2, 3, 0};
        do_reset();
        req = 4'b1111;
        for (int c = 0; c < 40 && order.size() < 5; c++) begin
            tick();
            checks++;
            if (got_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL rotation_cycle c=%0d got=%b exp=%b", c, got_vec(), exp_vec());
            end
            if (m_busy && m_cnt == 1) order.push_back(int'(gnt_idx));
            done = (m_busy && m_cnt == 2);
        end
        done = 1'b0;
        checks++;
        if (order.size() != 5) begin
            failures++;
            $display("FAIL rotation_count got=%0d exp=5", order.size());
        end
        for (int i = 0; i < order.size() && i < 5; i++) begin
            checks++;
            if (order[i] != want[i]) begin
                failures++;
                $display("FAIL rotation_order i=%0d got=%0d exp=%0d", i, order[i], want[i]);
            end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        req = 4'b0100;
        for (int c = 1; c <= 10; c++) begin
            logic [7:0] want;
            tick();
            if (c <= HOLD_MAX)          want = 8'b0100_10_1_0;
            else if (c == HOLD_MAX + 1) want = 8'b0000_00_0_1;
            else                        want = 8'b0100_10_1_0;
            checks++;
            if (got_vec() !== want || got_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL timeout_seq c=%0d got=%b exp=%b", c, got_vec(), want);
            end
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_abandon();
        do_reset();
        req = 4'b0010;
        tick();
        tick();
        checks++;
        if (gnt !== 4'b0010 || gnt_idx !== 2'd1) begin
            failures++;
            $display("FAIL abandon_owner got=%b exp=%b", got_vec(), 8'b0010_01_1_0);
        end
        req = 4'b1000;
        tick();
        checks++;
        if (got_vec() !== 8'b0) begin
            failures++;
            $display("FAIL abandon_release got=%b exp=%b", got_vec(), 8'b0);
        end
        tick();
        checks++;
        if (gnt !== 4'b1000 || gnt_idx !== 2'd3 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL abandon_next got=%b exp=%b", got_vec(), 8'b1000_11_1_0);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 4'b1000;
        tick();
        checks++;
        if (gnt !== 4'b1000 || gnt_idx !== 2'd3) begin
            failures++;
            $display("FAIL areset_pre got=%b exp=%b", got_vec(), 8'b1000_11_1_0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (got_vec() !== 8'b0) begin
            failures++;
            $display("FAIL areset_clear got=%b exp=%b", got_vec(), 8'b0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req   = 4'b1001;
        tick();
        checks++;
        if (gnt !== 4'b0001 || gnt_idx !== 2'd0) begin
            failures++;
            $display("FAIL areset_ptr got=%b exp=%b", got_vec(), 8'b0001_00_1_0);
        end
    endtask

    task automatic test_done_idle_coincident();
        do_reset();
        done = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (gnt_valid !== 1'b0 || gnt !== 4'b0000) begin
                failures++;
                $display("FAIL done_idle c=%0d got=%b exp=%b", c, got_vec(), 8'b0);
            end
        end
        done = 1'b0;
        req  = 4'b0001;
        for (int c = 0; c < HOLD_MAX; c++) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++;
        if (got_vec() !== 8'b0) begin
            failures++;
            $display("FAIL coincident_release got=%b exp=%b", got_vec(), 8'b0);
        end
        req = 4'b0011;
        tick();
        checks++;
        if (gnt !== 4'b0010 || gnt_idx !== 2'd1 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL coincident_rotate got=%b exp=%b", got_vec(), 8'b0010_01_1_0);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 500; c++) begin
            req  = 4'($urandom);
            done = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) != 0 && m_busy) req[m_owner] = 1'b1;
            tick();
            checks++;
            if (got_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random c=%0d req=%b got=%b exp=%b", c, req, got_vec(), exp_vec());
            end
            checks++;
            if (!$onehot0(gnt) || (gnt_valid && gnt !== 4'(1 << gnt_idx))) begin
                failures++;
                $display("FAIL random_invariant c=%0d got=%b exp=onehot", c, got_vec());
            end
        end
        req  = 4'b0000;
        done = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        model_reset();
        test_reset();
        test_single();
        test_rotation();
        test_timeout();
        test_abandon();
        test_async_reset();
        test_done_idle_coincident();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
